// File: rtl/bus_rdfifo.sv
// rtl/bus_rdfifo.sv - bus-attached readout FIFO drained by PS register-bus reads
//
// Fabric words enter through a valid/ready port. The PS drains them by reading
// the DATA offset, polls STATUS and writes CTRL. Read responses are registered
// and flagged with a one-cycle brdsel so the bus can OR-mux several slaves.
//
// Register map (BASE_ADDR[15:2] selects the block, baddr[1:0] the offset):
//   +0 DATA   read : head word and pop; 16'hDEAD when empty (sets unf)
//   +1 STATUS read : {full, empty, ovf, unf, count[11:0]}
//   +2 CTRL   read : {13'b0, enable, 2'b0}
//             write: bit0 flush, bit1 clear ovf/unf, bit2 enable
//   +3 PEEK   read : head word without pop (only with BUS_RDFIFO_PEEK_EN)
//
// Optional feature macro: BUS_RDFIFO_PEEK_EN (enables the +3 PEEK offset).
//
// Ports:
//   clk        bus clock
//   reset      asynchronous active-high reset
//   baddr      bus address
//   bwrdata    bus write data
//   bwr        1 = write, 0 = read (qualified by bstrobe)
//   bstrobe    one-cycle transaction strobe
//   brddata    registered read data, held until the next mapped read
//   brdsel     one-cycle flag that brddata carries this block's response
//   din        fabric data word
//   din_valid  fabric data valid
//   din_ready  enable & ~full
//   nonempty   registered count != 0

`timescale 1ns/1ps

module bus_rdfifo #(
  parameter logic [15:0] BASE_ADDR  = 16'h0100,
  parameter int          DEPTH_LOG2 = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baddr,
  input  logic [15:0] bwrdata,
  input  logic        bwr,
  input  logic        bstrobe,
  output logic [15:0] brddata,
  output logic        brdsel,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        nonempty
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [15:0]           EMPTY_WORD = 16'hDEAD;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  enable;
  logic                  ovf;
  logic                  unf;

  logic        hit;
  logic [1:0]  offset;
  logic        rd_hit;
  logic        ctrl_wr;
  logic        flush;
  logic        clr_flags;
  logic        empty;
  logic        full;
  logic        pop_req;
  logic        pop;
  logic        unf_set;
  logic        push_req;
  logic        push;
  logic        ovf_set;
  logic        rd_mapped;
  logic [15:0] head_word;
  logic [15:0] rd_word;
  logic [11:0] count12;
  logic        unused_bits;

  // CTRL bits above bit2 carry no function.
  assign unused_bits = ^bwrdata[15:3];

  assign hit       = bstrobe && (baddr[15:2] == BASE_ADDR[15:2]);
  assign offset    = baddr[1:0];
  assign rd_hit    = hit & ~bwr;
  assign ctrl_wr   = hit & bwr & (offset == 2'd2);
  assign flush     = ctrl_wr & bwrdata[0];
  assign clr_flags = ctrl_wr & bwrdata[1];

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A DATA read of an empty FIFO never touches storage; it only flags unf.
  assign pop_req = rd_hit & (offset == 2'd0);
  assign pop     = pop_req & ~empty;
  assign unf_set = pop_req & empty;

  // A flush discards any concurrent push without counting it as overflow.
  // When full, a same-cycle pop frees the slot the push lands in, so the
  // write goes to the address being read out on this edge.
  assign push_req = din_valid & enable & ~flush;
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  assign din_ready = enable & ~full;
  assign count12   = 12'(count);
  assign head_word = empty ? EMPTY_WORD : mem[rd_ptr];

`ifdef BUS_RDFIFO_PEEK_EN
  assign rd_mapped = 1'b1;
`else
  assign rd_mapped = (offset != 2'd3);
`endif

  always_comb begin
    rd_word = 16'h0000;
    case (offset)
      2'd0: rd_word = head_word;
      2'd1: rd_word = {full, empty, ovf, unf, count12};
      2'd2: rd_word = {13'b0, enable, 2'b0};
      default: begin
`ifdef BUS_RDFIFO_PEEK_EN
        rd_word = head_word;
`else
        rd_word = 16'h0000;
`endif
      end
    endcase
  end

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  // Storage has no reset; flushed or reset contents are simply unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      enable   <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      brddata  <= 16'h0000;
      brdsel   <= 1'b0;
      nonempty <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      count    <= count_next;
      nonempty <= (count_next != '0);
      // A new event outranks a clear issued on the same edge.
      ovf <= (ovf & ~clr_flags) | ovf_set;
      unf <= (unf & ~clr_flags) | unf_set;
      if (ctrl_wr) enable <= bwrdata[2];
      brdsel <= rd_hit & rd_mapped;
      if (rd_hit & rd_mapped) brddata <= rd_word;
    end
  end

endmodule

// File: tb/tb_bus_rdfifo.sv
// tb/tb_bus_rdfifo.sv - self-checking bench for bus_rdfifo

`timescale 1ns/1ps

module tb_bus_rdfifo;

  localparam logic [15:0] BASE = 16'h0100;
  localparam int          SDEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] baddr = '0;
  logic [15:0] bwrdata = '0;
  logic        bwr = 1'b0;
  logic        bstrobe = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;

  logic [15:0] brddata_b, brddata_s;
  logic        brdsel_b, brdsel_s;
  logic        din_ready_b, din_ready_s;
  logic        nonempty_b, nonempty_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_rdfifo #(.BASE_ADDR(BASE), .DEPTH_LOG2(9)) dut_b (
    .clk(clk), .reset(reset), .baddr(baddr), .bwrdata(bwrdata), .bwr(bwr),
    .bstrobe(bstrobe), .brddata(brddata_b), .brdsel(brdsel_b), .din(din),
    .din_valid(din_valid), .din_ready(din_ready_b), .nonempty(nonempty_b)
  );

  bus_rdfifo #(.BASE_ADDR(BASE), .DEPTH_LOG2(2)) dut_s (
    .clk(clk), .reset(reset), .baddr(baddr), .bwrdata(bwrdata), .bwr(bwr),
    .bstrobe(bstrobe), .brddata(brddata_s), .brdsel(brdsel_s), .din(din),
    .din_valid(din_valid), .din_ready(din_ready_s), .nonempty(nonempty_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bstrobe = 1'b0; bwr = 1'b0; baddr = '0; bwrdata = '0;
    din_valid = 1'b0; din = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [1:0] off);
    baddr = BASE + {14'b0, off}; bwr = 1'b0; bstrobe = 1'b1;
    tick();
    bstrobe = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [15:0] data);
    baddr = BASE + {14'b0, off}; bwr = 1'b1; bwrdata = data; bstrobe = 1'b1;
    tick();
    bstrobe = 1'b0; bwr = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    din = w; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    n_cmp++; if (brddata_b !== 16'h0000) begin n_bad++; $display("FAIL reset_brddata: got %h expected 0000", brddata_b); end
    n_cmp++; if (brdsel_b !== 1'b0) begin n_bad++; $display("FAIL reset_brdsel: got %b expected 0", brdsel_b); end
    n_cmp++; if (nonempty_b !== 1'b0) begin n_bad++; $display("FAIL reset_nonempty: got %b expected 0", nonempty_b); end
    n_cmp++; if (din_ready_b !== 1'b0) begin n_bad++; $display("FAIL reset_din_ready: got %b expected 0", din_ready_b); end
    reset = 1'b0;
    tick();
    bus_read(2'd1);
    n_cmp++; if (brddata_b !== 16'h4000 || brdsel_b !== 1'b1) begin n_bad++; $display("FAIL reset_status: got %h sel %b expected 4000 sel 1", brddata_b, brdsel_b); end
    bus_read(2'd0);
    n_cmp++; if (brddata_b !== 16'hDEAD) begin n_bad++; $display("FAIL empty_data: got %h expected dead", brddata_b); end
    bus_read(2'd1);
    n_cmp++; if (brddata_b !== 16'h5000) begin n_bad++; $display("FAIL unf_status: got %h expected 5000", brddata_b); end
    tick();
    n_cmp++; if (brdsel_b !== 1'b0 || brddata_b !== 16'h5000) begin n_bad++; $display("FAIL brdsel_drop: got sel %b data %h expected sel 0 data 5000", brdsel_b, brddata_b); end
  endtask

  task automatic test_drain();
    do_reset();
    bus_write(2'd2, 16'h0004);
    n_cmp++; if (din_ready_b !== 1'b1) begin n_bad++; $display("FAIL enable_ready: got %b expected 1", din_ready_b); end
    for (int i = 1; i <= 5; i++) push_word(16'(i));
    n_cmp++; if (nonempty_b !== 1'b1) begin n_bad++; $display("FAIL drain_nonempty: got %b expected 1", nonempty_b); end
    bus_read(2'd1);
    n_cmp++; if (brddata_b !== 16'h0005) begin n_bad++; $display("FAIL drain_status: got %h expected 0005", brddata_b); end
    baddr = BASE; bwr = 1'b0; bstrobe = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++; if (brddata_b !== 16'(i) || brdsel_b !== 1'b1) begin n_bad++; $display("FAIL drain_word%0d: got %h sel %b expected %h sel 1", i, brddata_b, brdsel_b, 16'(i)); end
      n_cmp++; if (nonempty_b !== (i < 5)) begin n_bad++; $display("FAIL drain_nonempty%0d: got %b expected %b", i, nonempty_b, (i < 5)); end
    end
    bstrobe = 1'b0;
    tick();
    n_cmp++; if (brdsel_b !== 1'b0 || brddata_b !== 16'h0005) begin n_bad++; $display("FAIL drain_hold: got sel %b data %h expected sel 0 data 0005", brdsel_b, brddata_b); end
  endtask

  task automatic test_full_and_wrap();
    logic [15:0] exp;
    do_reset();
    bus_write(2'd2, 16'h0004);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (din_ready_s !== (i < 4)) begin n_bad++; $display("FAIL full_ready%0d: got %b expected %b", i, din_ready_s, (i < 4)); end
      push_word(16'h00A0 + 16'(i));
    end
    bus_read(2'd1);
    n_cmp++; if (brddata_s !== 16'hA004) begin n_bad++; $display("FAIL full_status: got %h expected a004", brddata_s); end
    bus_write(2'd2, 16'h0006);
    bus_read(2'd1);
    n_cmp++; if (brddata_s !== 16'h8004) begin n_bad++; $display("FAIL clr_status: got %h expected 8004", brddata_s); end
    baddr = BASE; bwr = 1'b0; bstrobe = 1'b1; din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 16'h00C0 + 16'(i);
      tick();
      exp = (i < 4) ? 16'h00A0 + 16'(i) : 16'h00C0 + 16'(i - 4);
      n_cmp++; if (brddata_s !== exp || brdsel_s !== 1'b1) begin n_bad++; $display("FAIL wrap_word%0d: got %h sel %b expected %h sel 1", i, brddata_s, brdsel_s, exp); end
    end
    idle_inputs();
    bus_read(2'd1);
    n_cmp++; if (brddata_s !== 16'h8004) begin n_bad++; $display("FAIL wrap_status: got %h expected 8004", brddata_s); end
  endtask

  task automatic test_flush();
    do_reset();
    bus_write(2'd2, 16'h0004);
    for (int i = 0; i < 3; i++) push_word(16'h0100 + 16'(i));
    din = 16'h0077; din_valid = 1'b1;
    baddr = BASE + 16'd2; bwr = 1'b1; bwrdata = 16'h0005; bstrobe = 1'b1;
    tick();
    idle_inputs();
    bus_read(2'd1);
    n_cmp++; if (brddata_b !== 16'h4000) begin n_bad++; $display("FAIL flush_status: got %h expected 4000", brddata_b); end
    push_word(16'h1111);
    push_word(16'h2222);
    din = 16'h3333; din_valid = 1'b1;
    baddr = BASE; bwr = 1'b0; bstrobe = 1'b1;
    tick();
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (brddata_b !== 16'h0000 || brdsel_b !== 1'b0) begin n_bad++; $display("FAIL async_rst_bus: got %h sel %b expected 0000 sel 0", brddata_b, brdsel_b); end
    n_cmp++; if (nonempty_b !== 1'b0 || din_ready_b !== 1'b0) begin n_bad++; $display("FAIL async_rst_flags: got nonempty %b ready %b expected 0 0", nonempty_b, din_ready_b); end
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();
    bus_read(2'd1);
    n_cmp++; if (brddata_b !== 16'h4000) begin n_bad++; $display("FAIL rst_status: got %h expected 4000", brddata_b); end
  endtask

  task automatic test_peek();
    do_reset();
    bus_write(2'd2, 16'h0004);
    push_word(16'hBEEF);
    push_word(16'h1234);
    bus_read(2'd1);
    n_cmp++; if (brddata_b !== 16'h0002) begin n_bad++; $display("FAIL peek_pre_status: got %h expected 0002", brddata_b); end
    for (int i = 0; i < 2; i++) begin
      bus_read(2'd3);
`ifdef BUS_RDFIFO_PEEK_EN
      n_cmp++; if (brddata_b !== 16'hBEEF || brdsel_b !== 1'b1) begin n_bad++; $display("FAIL peek%0d: got %h sel %b expected beef sel 1", i, brddata_b, brdsel_b); end
`else
      n_cmp++; if (brddata_b !== 16'h0002 || brdsel_b !== 1'b0) begin n_bad++; $display("FAIL unmapped%0d: got %h sel %b expected 0002 sel 0", i, brddata_b, brdsel_b); end
`endif
    end
    bus_read(2'd1);
    n_cmp++; if (brddata_b !== 16'h0002) begin n_bad++; $display("FAIL peek_post_status: got %h expected 0002", brddata_b); end
    bus_write(2'd2, 16'h0005);
    bus_read(2'd3);
`ifdef BUS_RDFIFO_PEEK_EN
    n_cmp++; if (brddata_b !== 16'hDEAD || brdsel_b !== 1'b1) begin n_bad++; $display("FAIL peek_empty: got %h sel %b expected dead sel 1", brddata_b, brdsel_b); end
`else
    n_cmp++; if (brdsel_b !== 1'b0) begin n_bad++; $display("FAIL unmapped_empty: got sel %b expected 0", brdsel_b); end
`endif
    bus_read(2'd1);
    n_cmp++; if (brddata_b !== 16'h4000) begin n_bad++; $display("FAIL peek_empty_status: got %h expected 4000", brddata_b); end
  endtask

  // Queue-based reference for the depth-4 instance under random traffic.
  task automatic test_random();
    logic [15:0] q[$];
    logic        m_en, m_ovf, m_unf, m_sel;
    logic [15:0] m_rd;
    logic [1:0]  off;
    logic        hit, rd, wr_ctrl, m_flush, m_clr, pop_ok, push_ok, ovf_ev, unf_ev;
    int          sz;
    do_reset();
    q.delete();
    m_en = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_rd = 16'h0000;
    for (int c = 0; c < 600; c++) begin
      off = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      bstrobe = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 9))
        0:       baddr = BASE + 16'd4 + {14'b0, off};
        1:       baddr = BASE - 16'd4 + {14'b0, off};
        default: baddr = BASE + {14'b0, off};
      endcase
      bwr = (off == 2'd2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      bwrdata = {16'($urandom) & 16'hFFF8} |
                {13'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0)};
      din_valid = ($urandom_range(0, 3) != 0);
      din = 16'($urandom);

      sz = q.size();
      hit = bstrobe && (baddr[15:2] == BASE[15:2]);
      rd = hit && !bwr;
      wr_ctrl = hit && bwr && (baddr[1:0] == 2'd2);
      m_flush = wr_ctrl && bwrdata[0];
      m_clr = wr_ctrl && bwrdata[1];
      pop_ok = 1'b0; push_ok = 1'b0; ovf_ev = 1'b0; unf_ev = 1'b0; m_sel = 1'b0;
      if (rd) begin
        case (baddr[1:0])
          2'd0: begin
            m_sel = 1'b1;
            if (sz == 0) begin m_rd = 16'hDEAD; unf_ev = 1'b1; end
            else begin m_rd = q[0]; pop_ok = 1'b1; end
          end
          2'd1: begin m_sel = 1'b1; m_rd = {sz == SDEPTH, sz == 0, m_ovf, m_unf, 12'(sz)}; end
          2'd2: begin m_sel = 1'b1; m_rd = {13'b0, m_en, 2'b0}; end
          default: begin
`ifdef BUS_RDFIFO_PEEK_EN
            m_sel = 1'b1;
            m_rd = (sz == 0) ? 16'hDEAD : q[0];
`endif
          end
        endcase
      end
      if (din_valid && m_en && !m_flush) begin
        if (sz < SDEPTH || pop_ok) push_ok = 1'b1;
        else ovf_ev = 1'b1;
      end
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(din);
      if (m_flush) q.delete();
      m_ovf = (m_ovf && !m_clr) || ovf_ev;
      m_unf = (m_unf && !m_clr) || unf_ev;
      if (wr_ctrl) m_en = bwrdata[2];

      tick();
      n_cmp++; if (brdsel_s !== m_sel) begin n_bad++; $display("FAIL rnd_brdsel c%0d: got %b expected %b", c, brdsel_s, m_sel); end
      n_cmp++; if (brddata_s !== m_rd) begin n_bad++; $display("FAIL rnd_brddata c%0d: got %h expected %h", c, brddata_s, m_rd); end
      n_cmp++; if (nonempty_s !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_nonempty c%0d: got %b expected %b", c, nonempty_s, (q.size() != 0)); end
      n_cmp++; if (din_ready_s !== (m_en && q.size() < SDEPTH)) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, din_ready_s, (m_en && q.size() < SDEPTH)); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_drain();
    test_full_and_wrap();
    test_flush();
    test_peek();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
